// File: rtl/cpu_pkg.sv
// Shared constants and types for the 16-bit MIPS-style CPU front end.
package cpu_pkg;

    localparam int AW = 16;
    localparam int DW = 16;

    localparam logic [AW-1:0] RESET_PC   = 16'h0000;
    localparam logic [DW-1:0] HALT_INSTR = 16'hFFFF;
    localparam logic [DW-1:0] NOP_INSTR  = 16'h0000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    // Saturating 16-bit increment used by the fetch counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, its address, address+1 and a valid bit.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int             P_AW  = AW,
    parameter int             P_DW  = DW,
    parameter logic [P_DW-1:0] P_NOP = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_flush,
    input  logic [P_DW-1:0] i_instr,
    input  logic [P_AW-1:0] i_pc,
    output logic [P_DW-1:0] o_instr,
    output logic [P_AW-1:0] o_pc,
    output logic [P_AW-1:0] o_pc_next,
    output logic            o_valid
);

    logic [P_DW-1:0] r_instr;
    logic [P_AW-1:0] r_pc;
    logic [P_AW-1:0] r_pc_next;
    logic            r_valid;

    // Flush only squashes the instruction; the address fields are don't-care
    // while invalid, so they are left alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr   <= P_NOP;
            r_pc      <= '0;
            r_pc_next <= '0;
            r_valid   <= 1'b0;
        end else if (i_flush) begin
            r_instr   <= P_NOP;
            r_valid   <= 1'b0;
        end else if (i_load) begin
            r_instr   <= i_instr;
            r_pc      <= i_pc;
            r_pc_next <= i_pc + P_AW'(1);
            r_valid   <= 1'b1;
        end
    end

    assign o_instr   = r_instr;
    assign o_pc      = r_pc;
    assign o_pc_next = r_pc_next;
    assign o_valid   = r_valid;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the async instruction memory,
// fills IF/ID and stops on the HALT encoding until redirected.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              P_AW         = AW,
    parameter int              P_DW         = DW,
    parameter logic [P_AW-1:0] P_RESET_PC   = RESET_PC,
    parameter logic [P_DW-1:0] P_HALT_INSTR = HALT_INSTR,
    parameter logic [P_DW-1:0] P_NOP_INSTR  = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    output logic [P_AW-1:0] imem_addr,
    input  logic [P_DW-1:0] imem_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [P_AW-1:0] redirect_pc,
    output logic [P_DW-1:0] if_instr,
    output logic [P_AW-1:0] if_pc,
    output logic [P_AW-1:0] if_pc_next,
    output logic            if_valid,
    output logic            halted,
    output logic [15:0]     fetch_count
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [P_AW-1:0] r_pc;
    logic [P_AW-1:0] w_pc_nxt;
    logic [15:0]     r_fetch_count;
    logic            w_load;
    logic            w_flush;

    // imem_data is only inspected on the RUN/no-stall/no-redirect path, so an
    // unknown word on the bus while stalled or halted never reaches IF/ID.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        if (redirect_valid) begin
            w_flush     = 1'b1;
            w_pc_nxt    = redirect_pc;
            w_state_nxt = ST_RUN;
        end else if (stall) begin
            w_load      = 1'b0;
        end else if (r_state == ST_RUN) begin
            w_load = 1'b1;
            if (imem_data == P_HALT_INSTR) begin
                w_state_nxt = ST_HALTED;
            end else begin
                w_pc_nxt = r_pc + P_AW'(1);
            end
        end else begin
            w_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_pc          <= P_RESET_PC;
            r_fetch_count <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_load) begin
                r_fetch_count <= sat_inc16(r_fetch_count);
            end
        end
    end

    if_id_reg #(
        .P_AW  (P_AW),
        .P_DW  (P_DW),
        .P_NOP (P_NOP_INSTR)
    ) u_if_id (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_flush   (w_flush),
        .i_instr   (imem_data),
        .i_pc      (r_pc),
        .o_instr   (if_instr),
        .o_pc      (if_pc),
        .o_pc_next (if_pc_next),
        .o_valid   (if_valid)
    );

    assign imem_addr   = r_pc;
    assign halted      = (r_state == ST_HALTED);
    assign fetch_count = r_fetch_count;

endmodule
